// File: rtl/ref_fetch_pkg.sv
// Shared types and constants for the reference-frame fetch responder.
// Request bundle, read FSM states and error bit positions.
package ref_fetch_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W      = 16;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [LEN_W-1:0]      len;
  } req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } fsm_e;

  localparam int ERR_ZLEN  = 0;
  localparam int ERR_UNEXP = 1;

endpackage

// File: rtl/rfr_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Push and pop may coincide at any fill level, including full.
module rfr_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are qualified by the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ref_fetch_responder.sv
// Accepts burst requests, issues credit-limited word reads,
// and streams returned words in order to the reference consumer.
module ref_fetch_responder
  import ref_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REQ_DEPTH  = 2,
  parameter int BUF_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           len,
  output logic                  dram_ack,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0]     mem_rd_data,
  input  logic                  mem_rd_valid,
  output logic [DATA_W-1:0]     ref_data,
  output logic                  ref_data_valid,
  input  logic                  ref_ready,
  output logic                  busy,
  output logic [1:0]            err
);

  localparam int CW  = $clog2(BUF_DEPTH) + 1;
  localparam int RCW = $clog2(REQ_DEPTH) + 1;
  localparam int RW  = ADDR_WIDTH + LEN_W;

  fsm_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [CW-1:0]         infl_q, infl_d;
  logic                  dram_ack_q, dram_ack_d;
  logic [1:0]            err_q, err_d;

  logic                  accept;
  logic                  rq_push, rq_pop;
  logic [RW-1:0]         rq_dout;
  logic                  rq_full, rq_empty;
  logic [RCW-1:0]        rq_count;
  logic [ADDR_WIDTH-1:0] rq_addr;
  logic [LEN_W-1:0]      rq_len;

  logic                  rb_push, rb_pop;
  logic [DATA_W-1:0]     rb_dout;
  logic                  rb_full, rb_empty;
  logic [CW-1:0]         rb_count;

  logic                  rd_en;
  logic                  can_issue;
  logic                  ret_ok;

  assign accept  = issue_req && !dram_ack_q && !rq_full;
  assign rq_push = accept && (len != '0);
  assign rq_addr = rq_dout[RW-1:LEN_W];
  assign rq_len  = rq_dout[LEN_W-1:0];
  assign ret_ok  = mem_rd_valid && (infl_q != '0);
  assign rb_push = ret_ok;
  assign rb_pop  = ref_ready;

  // Outstanding reads plus buffered words never exceed the buffer.
  assign can_issue = !rb_full &&
    (({1'b0, infl_q} + {1'b0, rb_count}) < (CW+1)'(BUF_DEPTH));

  rfr_sync_fifo #(
    .WIDTH (RW),
    .DEPTH (REQ_DEPTH),
    .CW    (RCW)
  ) u_req_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rq_push),
    .din   ({addr, len}),
    .pop   (rq_pop),
    .dout  (rq_dout),
    .full  (rq_full),
    .empty (rq_empty),
    .count (rq_count)
  );

  rfr_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_ret_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rb_push),
    .din   (mem_rd_data),
    .pop   (rb_pop),
    .dout  (rb_dout),
    .full  (rb_full),
    .empty (rb_empty),
    .count (rb_count)
  );

  // Accept pulse and sticky error flags.
  always_comb begin
    dram_ack_d = accept;
    err_d      = err_q;
    if (accept && (len == '0)) err_d[ERR_ZLEN] = 1'b1;
    if (mem_rd_valid && (infl_q == '0)) err_d[ERR_UNEXP] = 1'b1;
  end

  // Read FSM: load a burst, then issue one word per credit.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    rq_pop     = 1'b0;
    rd_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rq_empty) begin
          rq_pop     = 1'b1;
          cur_addr_d = rq_addr;
          rem_d      = rq_len;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (can_issue) begin
          rd_en      = 1'b1;
          cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
          rem_d      = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            if (!rq_empty) begin
              rq_pop     = 1'b1;
              cur_addr_d = rq_addr;
              rem_d      = rq_len;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read credit counter.
  always_comb begin
    infl_d = infl_q;
    unique case ({rd_en, ret_ok})
      2'b10:   infl_d = infl_q + CW'(1);
      2'b01:   infl_d = infl_q - CW'(1);
      default: infl_d = infl_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      infl_q     <= '0;
      dram_ack_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      infl_q     <= infl_d;
      dram_ack_q <= dram_ack_d;
      err_q      <= err_d;
    end
  end

  assign dram_ack       = dram_ack_q;
  assign mem_rd_en      = rd_en;
  assign mem_rd_addr    = cur_addr_q;
  assign ref_data_valid = !rb_empty;
  assign ref_data       = rb_empty ? '0 : rb_dout;
  assign err            = err_q;
  assign busy           = (rq_count != '0) || (state_q == BURST) ||
                          (infl_q != '0) || !rb_empty;

endmodule

// File: tb/tb_ref_fetch_responder.sv
// Randomized bench for ref_fetch_responder with a memory model
// and an in-order scoreboard built from accepted bursts.
module tb_ref_fetch_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_req;
  logic [31:0] addr;
  logic [15:0] len;
  logic        dram_ack;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic        mem_rd_valid;
  logic [15:0] ref_data;
  logic        ref_data_valid;
  logic        ref_ready;
  logic        busy;
  logic [1:0]  err;

  always #5 clk = ~clk;

  ref_fetch_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_req      (issue_req),
    .addr           (addr),
    .len            (len),
    .dram_ack       (dram_ack),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_data    (mem_rd_data),
    .mem_rd_valid   (mem_rd_valid),
    .ref_data       (ref_data),
    .ref_data_valid (ref_data_valid),
    .ref_ready      (ref_ready),
    .busy           (busy),
    .err            (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mdata(input logic [31:0] a);
    return a[15:0] ^ {a[23:16], a[31:24]} ^ 16'h5A3C;
  endfunction

  typedef struct {
    logic [31:0] a;
    int          due;
  } rd_t;

  logic [31:0] exp_addr [$];
  logic [15:0] exp_data [$];
  rd_t         pend [$];
  int          iss_log [$];

  int cyc       = 0;
  int issued    = 0;
  int delivered = 0;
  int last_due  = 0;
  int rdy_mode  = 1;
  int lat_fix   = 0;
  int inj_req   = 0;
  int inj_done  = 0;
  int mrst_req  = 0;
  int mrst_done = 0;

  // Memory model, consumer and scoreboard, all at the falling edge.
  always @(negedge clk) begin
    int lat;
    int due;
    rd_t r;
    cyc++;
    if (mrst_req != mrst_done) begin
      mrst_done = mrst_req;
      pend.delete();
    end
    if (mem_rd_en) begin
      issued++;
      iss_log.push_back(cyc);
      if (exp_addr.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd_addr", mem_rd_addr, exp_addr.pop_front());
      lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      r.a = mem_rd_addr;
      r.due = due;
      pend.push_back(r);
    end
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    if (inj_req != inj_done) begin
      inj_done     = inj_req;
      mem_rd_valid = 1'b1;
      mem_rd_data  = 16'hDEAD;
    end else if (pend.size() != 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      mem_rd_valid = 1'b1;
      mem_rd_data  = mdata(r.a);
    end
    ref_ready = (rdy_mode == 1) ||
                (rdy_mode == 2 && $urandom_range(0, 3) != 0);
    if (ref_data_valid && ref_ready) begin
      delivered++;
      if (exp_data.size() == 0) chk("out_unexpected", 1, 0);
      else chk("ref_data", ref_data, exp_data.pop_front());
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic req_start(input logic [31:0] a, input logic [15:0] l);
    issue_req = 1'b1;
    addr      = a;
    len       = l;
  endtask

  task automatic wait_ack(input int max, output bit ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (dram_ack) begin
        ok  = 1'b1;
        lat = i;
        break;
      end
    end
    if (ok) begin
      issue_req = 1'b0;
      for (int k = 0; k < int'(len); k++) begin
        exp_addr.push_back(addr + 32'(k));
        exp_data.push_back(mdata(addr + 32'(k)));
      end
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [15:0] l,
                      output int lat);
    bit ok;
    req_start(a, l);
    wait_ack(100, ok, lat);
    chk("ack_timeout", ok, 1);
  endtask

  task automatic wait_idle(input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (!busy && !ref_data_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", ok, 1);
    chk("drain_left", exp_data.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, n0, d0, i0, n;
    bit  ok, bsy;
    rst_n     = 1'b0;
    issue_req = 1'b0;
    addr      = '0;
    len       = '0;
    repeat (3) tick();
    chk("reset_out", {dram_ack, mem_rd_en, mem_rd_addr, ref_data,
                      ref_data_valid, busy, err}, 0);
    rst_n = 1'b1;
    tick();

    // Single burst, fixed latency 2, always ready.
    lat_fix  = 2;
    rdy_mode = 1;
    n0 = iss_log.size();
    d0 = delivered;
    send(32'h100, 16'd4, lat);
    chk("t1_ack_lat", lat, 1);
    wait_idle(100);
    n = iss_log.size() - n0;
    chk("t1_reads", n, 4);
    chk("t1_span", iss_log[n0+n-1] - iss_log[n0] + 1, 4);
    chk("t1_words", delivered - d0, 4);

    // Back-to-back bursts must issue without a bubble.
    lat_fix = 0;
    n0 = iss_log.size();
    send(32'h400, 16'd2, lat);
    send(32'h500, 16'd3, lat);
    send(32'h600, 16'd1, lat);
    wait_idle(200);
    n = iss_log.size() - n0;
    chk("t2_reads", n, 6);
    chk("t2_span", iss_log[n0+n-1] - iss_log[n0] + 1, 6);

    // Consumer stall: credits cap reads, request queue fills.
    rdy_mode = 0;
    i0 = issued;
    send(32'h2000, 16'd16, lat);
    repeat (20) tick();
    chk("t3_stall_reads", issued - i0, 8);
    send(32'h3000, 16'd2, lat);
    send(32'h3100, 16'd3, lat);
    req_start(32'h3200, 16'd1);
    wait_ack(8, ok, lat);
    chk("t3_full_noack", ok, 0);
    rdy_mode = 1;
    wait_ack(300, ok, lat);
    chk("t3_late_ack", ok, 1);
    wait_idle(500);
    chk("t3_total_reads", issued - i0, 22);

    // Zero-length request.
    i0 = issued;
    send(32'h7000, 16'd0, lat);
    chk("t4_ack_lat", lat, 1);
    bsy = busy;
    repeat (5) begin
      tick();
      bsy = bsy | busy;
    end
    chk("t4_no_reads", issued - i0, 0);
    chk("t4_err", err, 2'b01);
    chk("t4_busy", bsy, 0);

    // Address wrap at the top of the space.
    send(32'hFFFF_FFFE, 16'd4, lat);
    wait_idle(100);

    // Random bursts, random latency and backpressure.
    rdy_mode = 2;
    for (int b = 0; b < 25; b++) begin
      send($urandom, 16'($urandom_range(1, 12)), lat);
      repeat ($urandom_range(0, 6)) tick();
    end
    wait_idle(3000);

    // Reset in the middle of a burst.
    rdy_mode = 1;
    i0 = issued;
    send(32'h5000, 16'd10, lat);
    for (int i = 0; i < 60 && (issued - i0) < 5; i++) tick();
    chk("t6_mid_burst", (issued - i0) >= 5, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out", {dram_ack, mem_rd_en, mem_rd_addr, ref_data,
                       ref_data_valid, busy, err}, 0);
    exp_addr.delete();
    exp_data.delete();
    mrst_req++;
    tick();
    tick();
    chk("t6_rst_hold", {dram_ack, mem_rd_en, mem_rd_addr, ref_data,
                        ref_data_valid, busy, err}, 0);
    rst_n = 1'b1;
    tick();
    inj_req++;
    tick();
    tick();
    chk("t6_err_unexp", err, 2'b10);
    chk("t6_dropped", {ref_data_valid, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
